// File: rtl/tmds_pll_pkg.sv
// Shared types and constants for the TMDS PLL lock supervisor.
//   pll_sup_state_t : supervisor FSM state encoding
//   Def*Cyc         : default cycle counts for a 27 MHz reference clock
//   cnt_width()     : width of the shared cycle counter
package tmds_pll_pkg;

  typedef enum logic [1:0] {
    StPllRst,  // PLL RESET pin held high
    StWait,    // waiting for lock, bounded by the lock timeout
    StStable,  // lock seen, qualifying it for the stable time
    StRun      // lock qualified, video domain released
  } pll_sup_state_t;

  localparam int unsigned DefPllRstCyc      = 27;     // 1 us
  localparam int unsigned DefLockTimeoutCyc = 27000;  // 1 ms
  localparam int unsigned DefLockStableCyc  = 2700;   // 100 us

  // Bits needed to hold the largest of the three cycle counts.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    int unsigned w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops reset to 0
//   d     : asynchronous input
//   q     : synchronized output, two clk edges behind d
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tmds_pll_supervisor.sv
// Lock supervisor and reset sequencer for the HDMI TMDS PLL.
// Pulses the PLL RESET pin, waits (with timeout and retry count) for lock, qualifies lock for a
// stable time and only then releases the TMDS/pixel domain. Lock loss or a relock request
// re-sequences the PLL.
//   clk         : 27 MHz reference clock (same as PLL clkin)
//   rst_n       : asynchronous active-low reset
//   lock        : PLL lock, asynchronous to clk
//   relock_req  : single-cycle pulse forcing a full PLL re-sequence
//   pll_reset   : PLL RESET pin, active high
//   video_rst_n : reset request for the TMDS/pixel domain, active low
//   pll_ready   : high only while running with qualified lock
//   retry_cnt   : saturating count of lock timeouts since reset
//   retry_sat   : retry_cnt is all-ones
module tmds_pll_supervisor
  import tmds_pll_pkg::*;
#(
  parameter int unsigned PLL_RST_CYC      = DefPllRstCyc,
  parameter int unsigned LOCK_TIMEOUT_CYC = DefLockTimeoutCyc,
  parameter int unsigned LOCK_STABLE_CYC  = DefLockStableCyc,
  parameter int unsigned RETRY_W          = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lock,
  input  logic               relock_req,
  output logic               pll_reset,
  output logic               video_rst_n,
  output logic               pll_ready,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               retry_sat
);

  localparam int unsigned CntW = cnt_width(PLL_RST_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t RstLast     = cnt_t'(PLL_RST_CYC - 1);
  localparam cnt_t TimeoutLast = cnt_t'(LOCK_TIMEOUT_CYC - 1);
  localparam cnt_t StableLast  = cnt_t'(LOCK_STABLE_CYC - 1);

  logic               lock_s;
  pll_sup_state_t     state_q, state_d;
  cnt_t               cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_d;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (lock),
    .q     (lock_s)
  );

  // Next-state decode. Priority: relock_req, then lock_s events, then terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_cnt;
    unique case (state_q)
      StPllRst: begin
        // relock_req is deliberately ignored here; the pulse is not restarted.
        if (cnt_q == RstLast) begin
          state_d = StWait;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      StWait: begin
        if (relock_req) begin
          state_d = StPllRst;
          cnt_d   = '0;
        end else if (lock_s) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          // Saturate rather than wrap; retries continue indefinitely.
          retry_d = (&retry_cnt) ? retry_cnt : retry_cnt + RETRY_W'(1);
          state_d = StPllRst;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      StStable: begin
        if (relock_req) begin
          state_d = StPllRst;
          cnt_d   = '0;
        end else if (!lock_s) begin
          // Lock glitch: restart the timeout window without counting a retry.
          state_d = StWait;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      StRun: begin
        if (relock_req) begin
          state_d = StPllRst;
          cnt_d   = '0;
        end else if (!lock_s) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StPllRst;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StPllRst;
      cnt_q       <= '0;
      retry_cnt   <= '0;
      retry_sat   <= 1'b0;
      pll_reset   <= 1'b1;
      video_rst_n <= 1'b0;
      pll_ready   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_cnt   <= retry_d;
      retry_sat   <= &retry_d;
      pll_reset   <= (state_d == StPllRst);
      video_rst_n <= (state_d == StRun);
      pll_ready   <= (state_d == StRun);
    end
  end

endmodule

// File: tb/tb_tmds_pll_supervisor.sv
// Directed self-checking bench for tmds_pll_supervisor with short cycle parameters.
module tb_tmds_pll_supervisor;

  localparam int unsigned RstCyc     = 4;
  localparam int unsigned TimeoutCyc = 20;
  localparam int unsigned StableCyc  = 8;
  localparam int unsigned RetryW     = 4;

  logic              clk;
  logic              rst_n;
  logic              lock;
  logic              relock_req;
  logic              pll_reset;
  logic              video_rst_n;
  logic              pll_ready;
  logic [RetryW-1:0] retry_cnt;
  logic              retry_sat;

  int n_checks;
  int n_fail;

  tmds_pll_supervisor #(
    .PLL_RST_CYC      (RstCyc),
    .LOCK_TIMEOUT_CYC (TimeoutCyc),
    .LOCK_STABLE_CYC  (StableCyc),
    .RETRY_W          (RetryW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lock        (lock),
    .relock_req  (relock_req),
    .pll_reset   (pll_reset),
    .video_rst_n (video_rst_n),
    .pll_ready   (pll_ready),
    .retry_cnt   (retry_cnt),
    .retry_sat   (retry_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    lock       = 1'b0;
    relock_req = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (pll_reset !== 1'b1) begin
      n_fail++; $display("FAIL reset_pll_reset: got %b want 1", pll_reset);
    end
    n_checks++;
    if (video_rst_n !== 1'b0) begin
      n_fail++; $display("FAIL reset_video_rst_n: got %b want 0", video_rst_n);
    end
    n_checks++;
    if (pll_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_pll_ready: got %b want 0", pll_ready);
    end
    n_checks++;
    if (retry_cnt !== 4'd0) begin
      n_fail++; $display("FAIL reset_retry_cnt: got %0d want 0", retry_cnt);
    end
    n_checks++;
    if (retry_sat !== 1'b0) begin
      n_fail++; $display("FAIL reset_retry_sat: got %b want 0", retry_sat);
    end
  endtask

  task automatic test_power_up();
    int n;
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if (pll_reset !== 1'b1) begin
        n_fail++; $display("FAIL pu_pll_reset_high edge %0d: got %b want 1", i, pll_reset);
      end
    end
    tick();
    n_checks++;
    if (pll_reset !== 1'b0) begin
      n_fail++; $display("FAIL pu_pll_reset_fall edge 4: got %b want 0", pll_reset);
    end
    repeat (6) tick();
    lock = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (video_rst_n !== 1'b1 && n < 40);
    n_checks++;
    if (n != 11) begin
      n_fail++; $display("FAIL pu_video_release: rose after %0d edges want 11", n);
    end
    n_checks++;
    if (pll_ready !== 1'b1) begin
      n_fail++; $display("FAIL pu_pll_ready: got %b want 1", pll_ready);
    end
    n_checks++;
    if (retry_cnt !== 4'd0) begin
      n_fail++; $display("FAIL pu_retry_cnt: got %0d want 0", retry_cnt);
    end
  endtask

  task automatic test_lock_loss_run();
    int n;
    logic pulsed;
    lock = 1'b0;
    tick();
    tick();
    n_checks++;
    if (video_rst_n !== 1'b1) begin
      n_fail++; $display("FAIL loss_early: video_rst_n %b after 2 edges want 1", video_rst_n);
    end
    tick();
    n_checks++;
    if (video_rst_n !== 1'b0) begin
      n_fail++; $display("FAIL loss_video_fall: video_rst_n %b after 3 edges want 0", video_rst_n);
    end
    n_checks++;
    if (pll_ready !== 1'b0) begin
      n_fail++; $display("FAIL loss_pll_ready: got %b want 0", pll_ready);
    end
    pulsed = 1'b0;
    repeat (2) begin
      tick();
      pulsed |= pll_reset;
    end
    lock = 1'b1;
    n = 0;
    do begin
      tick();
      pulsed |= pll_reset;
      n++;
    end while (video_rst_n !== 1'b1 && n < 40);
    n_checks++;
    if (n != 11) begin
      n_fail++; $display("FAIL loss_relock_time: RUN after %0d edges want 11", n);
    end
    n_checks++;
    if (pulsed !== 1'b0) begin
      n_fail++; $display("FAIL loss_no_pll_pulse: pll_reset seen %b want 0", pulsed);
    end
    n_checks++;
    if (retry_cnt !== 4'd0) begin
      n_fail++; $display("FAIL loss_retry_cnt: got %0d want 0", retry_cnt);
    end
  endtask

  task automatic test_glitchy_lock();
    int n;
    logic pulsed;
    pulsed = 1'b0;
    // Leave RUN, then requalify up to stable count 5.
    lock = 1'b0;
    repeat (3) tick();
    lock = 1'b1;
    repeat (8) tick();
    // Glitch lands so that lock_s drop coincides with the stable terminal count.
    lock = 1'b0;
    repeat (3) begin
      tick();
      pulsed |= pll_reset;
    end
    n_checks++;
    if (video_rst_n !== 1'b0) begin
      n_fail++; $display("FAIL glitch_no_run: video_rst_n %b want 0", video_rst_n);
    end
    lock = 1'b1;
    n = 0;
    do begin
      tick();
      pulsed |= pll_reset;
      n++;
    end while (video_rst_n !== 1'b1 && n < 40);
    n_checks++;
    if (n != 11) begin
      n_fail++; $display("FAIL glitch_requalify: RUN after %0d edges want 11", n);
    end
    n_checks++;
    if (pulsed !== 1'b0) begin
      n_fail++; $display("FAIL glitch_no_pll_pulse: pll_reset seen %b want 0", pulsed);
    end
    n_checks++;
    if (retry_cnt !== 4'd0) begin
      n_fail++; $display("FAIL glitch_retry_cnt: got %0d want 0", retry_cnt);
    end
  endtask

  task automatic test_relock();
    int n;
    // Plain relock from RUN; a second pulse inside PLLRST must be ignored.
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    n_checks++;
    if (pll_reset !== 1'b1 || video_rst_n !== 1'b0 || pll_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL relock_enter: pll_reset %b video_rst_n %b pll_ready %b want 1 0 0",
               pll_reset, video_rst_n, pll_ready);
    end
    for (int i = 1; i <= 3; i++) begin
      if (i == 2) relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      n_checks++;
      if (pll_reset !== 1'b1) begin
        n_fail++; $display("FAIL relock_pulse_high edge %0d: got %b want 1", i, pll_reset);
      end
    end
    tick();
    n_checks++;
    if (pll_reset !== 1'b0) begin
      n_fail++; $display("FAIL relock_pulse_len: pll_reset %b after 4 edges want 0", pll_reset);
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (video_rst_n !== 1'b1 && n < 40);
    n_checks++;
    if (n != 9) begin
      n_fail++; $display("FAIL relock_run: RUN after %0d edges want 9", n);
    end
    // Relock together with a lock drop: relock wins.
    relock_req = 1'b1;
    lock       = 1'b0;
    tick();
    relock_req = 1'b0;
    n_checks++;
    if (pll_reset !== 1'b1 || video_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL relock_priority: pll_reset %b video_rst_n %b want 1 0", pll_reset,
               video_rst_n);
    end
    repeat (3) tick();
    n_checks++;
    if (pll_reset !== 1'b1) begin
      n_fail++; $display("FAIL relock2_high: pll_reset %b want 1", pll_reset);
    end
    tick();
    n_checks++;
    if (pll_reset !== 1'b0) begin
      n_fail++; $display("FAIL relock2_fall: pll_reset %b want 0", pll_reset);
    end
    lock = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (video_rst_n !== 1'b1 && n < 40);
    n_checks++;
    if (n != 11) begin
      n_fail++; $display("FAIL relock2_run: RUN after %0d edges want 11", n);
    end
    n_checks++;
    if (retry_cnt !== 4'd0) begin
      n_fail++; $display("FAIL relock_retry_cnt: got %0d want 0", retry_cnt);
    end
  endtask

  task automatic test_no_lock();
    int unsigned exp_retry;
    lock = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (video_rst_n !== 1'b0) begin
      n_fail++; $display("FAIL nolock_enter_wait: video_rst_n %b want 0", video_rst_n);
    end
    for (int k = 1; k <= 16; k++) begin
      exp_retry = (k > 15) ? 15 : k;
      for (int i = 1; i < int'(TimeoutCyc); i++) begin
        tick();
        n_checks++;
        if (pll_reset !== 1'b0) begin
          n_fail++; $display("FAIL nolock_wait_low try %0d cyc %0d: got %b want 0", k, i,
                             pll_reset);
        end
      end
      tick();
      n_checks++;
      if (pll_reset !== 1'b1) begin
        n_fail++; $display("FAIL nolock_timeout try %0d: pll_reset %b want 1", k, pll_reset);
      end
      n_checks++;
      if (retry_cnt !== exp_retry[RetryW-1:0]) begin
        n_fail++; $display("FAIL nolock_retry_cnt try %0d: got %0d want %0d", k, retry_cnt,
                           exp_retry);
      end
      n_checks++;
      if (retry_sat !== (k >= 15)) begin
        n_fail++; $display("FAIL nolock_retry_sat try %0d: got %b want %b", k, retry_sat,
                           (k >= 15));
      end
      repeat (3) tick();
      n_checks++;
      if (pll_reset !== 1'b1) begin
        n_fail++; $display("FAIL nolock_pulse_high try %0d: got %b want 1", k, pll_reset);
      end
      tick();
      n_checks++;
      if (pll_reset !== 1'b0) begin
        n_fail++; $display("FAIL nolock_pulse_fall try %0d: got %b want 0", k, pll_reset);
      end
    end
  endtask

  task automatic test_mid_reset();
    int n;
    // In WAIT with retry_cnt saturated; get into STABLE, then reset.
    lock = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (pll_reset !== 1'b1 || video_rst_n !== 1'b0 || pll_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: pll_reset %b video_rst_n %b pll_ready %b want 1 0 0",
               pll_reset, video_rst_n, pll_ready);
    end
    n_checks++;
    if (retry_cnt !== 4'd0 || retry_sat !== 1'b0) begin
      n_fail++; $display("FAIL midrst_retry: retry_cnt %0d retry_sat %b want 0 0", retry_cnt,
                         retry_sat);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if (pll_reset !== 1'b1) begin
        n_fail++; $display("FAIL midrst_pll_high edge %0d: got %b want 1", i, pll_reset);
      end
    end
    n = 3;
    do begin
      tick();
      n++;
    end while (video_rst_n !== 1'b1 && n < 40);
    n_checks++;
    if (n != 13) begin
      n_fail++; $display("FAIL midrst_restart: RUN after %0d edges want 13", n);
    end
    n_checks++;
    if (retry_cnt !== 4'd0) begin
      n_fail++; $display("FAIL midrst_retry_after: got %0d want 0", retry_cnt);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_power_up();
    test_lock_loss_run();
    test_glitchy_lock();
    test_relock();
    test_no_lock();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
